// File: rtl/trap_unit.sv
// trap_unit: trap sequencer at the write-back boundary.
// It picks one event per cycle from a synchronous exception, an enabled pending
// interrupt or an MRET. It raises the CSR-file strobes for that event, then
// flushes the front of the pipe and redirects fetch to the registered target.
module trap_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mie_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_pc_i,
  input  logic        exc_taken_i,
  input  logic        mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        fetch_ready_i,
  output logic        kill_wb_o,
  output logic        int_taken_o,
  output logic [31:0] int_mcause_o,
  output logic [31:0] int_mepc_o,
  output logic        mret_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target_p1;
  logic [31:0] target_nxt;
  logic        en_mei;
  logic        en_msi;
  logic        en_mti;
  logic        int_any;
  logic        int_req;
  logic [3:0]  int_code;
  logic        idle;
  logic        exc_acc;
  logic        int_acc;
  logic        mret_acc;
  logic        evt_acc;

  // Enable bits and address bits that never influence the trap decision.
  logic unused_bits;
  assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mepc_i[1:0]};

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] align4(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Interrupt entry point: base + 4*code in vectored mode, base otherwise (wraps mod 2^32).
  function automatic logic [31:0] int_vector(input logic [31:0] mtvec, input logic [3:0] code);
    logic [31:0] vec;
    if (mtvec[1:0] == 2'b01)
      vec = align4(mtvec) + {26'd0, code, 2'b00};
    else
      vec = align4(mtvec);
    return vec;
  endfunction

  // Event arbitration: exception over interrupt over MRET, only while idle and out of reset.
  always_comb begin
    en_mei  = xint_meip_i & mie_i[11];
    en_msi  = xint_msip_i & mie_i[3];
    en_mti  = xint_mtip_i & mie_i[7];
    int_any = en_mei | en_msi | en_mti;
    if (en_mei)
      int_code = 4'd11;
    else if (en_msi)
      int_code = 4'd3;
    else
      int_code = 4'd7;
    idle     = rst_i & (state == IDLE);
    int_req  = mstatus_mie_i & wb_valid_i & ~exc_taken_i & int_any;
    exc_acc  = idle & exc_taken_i;
    int_acc  = idle & int_req;
    mret_acc = idle & ~exc_taken_i & ~int_req & mret_i;
    evt_acc  = exc_acc | int_acc | mret_acc;
    if (exc_acc)
      target_nxt = align4(mtvec_i);
    else if (int_acc)
      target_nxt = int_vector(mtvec_i, int_code);
    else
      target_nxt = align4(mepc_i);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: accept -> one flush cycle -> hold redirect until fetch takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (evt_acc) state_nxt = FLUSH;
      FLUSH:    state_nxt = REDIRECT;
      REDIRECT: if (fetch_ready_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Target register: captured only on an accepted event so it stays stable while busy.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      target_p1 <= RESET_PC;
    else if (evt_acc)
      target_p1 <= target_nxt;
  end

  // Outputs: strobes are combinational in the accept cycle, sequencing decodes the state.
  always_comb begin
    kill_wb_o        = int_acc;
    int_taken_o      = int_acc;
    int_mcause_o     = int_acc ? {1'b1, 27'd0, int_code} : 32'd0;
    int_mepc_o       = int_acc ? wb_pc_i : 32'd0;
    mret_o           = mret_acc;
    flush_o          = (state == FLUSH);
    redirect_valid_o = (state == REDIRECT);
    redirect_pc_o    = target_p1;
    busy_o           = (state != IDLE);
  end

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed scenarios plus randomized traffic for trap_unit,
// checked every cycle against a behavioural model of the trap sequence.
module tb_trap_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        xint_meip_i, xint_mtip_i, xint_msip_i;
  logic        mstatus_mie_i;
  logic [31:0] mie_i;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic        exc_taken_i;
  logic        mret_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        fetch_ready_i;
  logic        kill_wb_o, int_taken_o, mret_o, flush_o, redirect_valid_o, busy_o;
  logic [31:0] int_mcause_o, int_mepc_o, redirect_pc_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: age = -1 when idle, else cycles since the accepted event (1 = flush, >=2 = redirect).
  int          age = -1;
  logic [31:0] exp_pc = RST_PC;
  bit          ev_any;
  logic [31:0] ev_target;

  always #5 clk = ~clk;

  trap_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
    .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i),
    .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .exc_taken_i(exc_taken_i), .mret_i(mret_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .fetch_ready_i(fetch_ready_i),
    .kill_wb_o(kill_wb_o), .int_taken_o(int_taken_o),
    .int_mcause_o(int_mcause_o), .int_mepc_o(int_mepc_o),
    .mret_o(mret_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst_i = 1'b1;
    xint_meip_i = 0; xint_mtip_i = 0; xint_msip_i = 0;
    mstatus_mie_i = 0; mie_i = 32'd0;
    wb_valid_i = 0; wb_pc_i = 32'd0;
    exc_taken_i = 0; mret_i = 0;
    mtvec_i = 32'd0; mepc_i = 32'd0;
    fetch_ready_i = 1'b1;
  endtask

  // Mid-cycle: compute what the spec demands for the present inputs and compare everything.
  task automatic sample();
    bit          idle;
    int          code;
    int          prio [3];
    logic [31:0] pend;
    logic [31:0] base;
    bit          e_int, e_mret;
    @(negedge clk);
    prio = '{11, 3, 7};
    pend = 32'd0;
    pend[11] = xint_meip_i;
    pend[7]  = xint_mtip_i;
    pend[3]  = xint_msip_i;
    idle = (age < 0) && rst_i;
    code = -1;
    if (idle && mstatus_mie_i && wb_valid_i && !exc_taken_i)
      foreach (prio[k])
        if (code < 0 && pend[prio[k]] && mie_i[prio[k]]) code = prio[k];
    e_int  = (code >= 0);
    e_mret = idle && !exc_taken_i && !e_int && mret_i;
    ev_any = idle && (exc_taken_i || e_int || e_mret);
    base   = mtvec_i & 32'hFFFF_FFFC;
    if (idle && exc_taken_i)   ev_target = base;
    else if (e_int)            ev_target = (mtvec_i[1:0] == 2'b01) ? base + 32'(code) * 32'd4 : base;
    else                       ev_target = mepc_i & 32'hFFFF_FFFC;
    chk("kill_wb",   {31'd0, kill_wb_o},   {31'd0, e_int});
    chk("int_taken", {31'd0, int_taken_o}, {31'd0, e_int});
    chk("mcause",    int_mcause_o, e_int ? (32'h8000_0000 | 32'(code)) : 32'd0);
    chk("mepc",      int_mepc_o,   e_int ? wb_pc_i : 32'd0);
    chk("mret",      {31'd0, mret_o},  {31'd0, e_mret});
    chk("flush",     {31'd0, flush_o}, {31'd0, age == 1});
    chk("redir_vld", {31'd0, redirect_valid_o}, {31'd0, age >= 2});
    chk("busy",      {31'd0, busy_o},  {31'd0, age >= 1});
    chk("redir_pc",  redirect_pc_o, exp_pc);
  endtask

  // Clock edge: advance the model with the inputs that were present at the edge.
  task automatic advance();
    @(posedge clk);
    if (!rst_i) begin
      age = -1; exp_pc = RST_PC;
    end else if (ev_any) begin
      age = 1; exp_pc = ev_target;
    end else if (age == 1) begin
      age = 2;
    end else if (age >= 2 && fetch_ready_i) begin
      age = -1;
    end else if (age >= 2) begin
      age = age + 1;
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;

    // Reset state
    sample();
    chk("rst_pc", redirect_pc_o, RST_PC);
    advance();

    // Exception to mtvec base, mode bits stripped
    mtvec_i = 32'h0000_0101; exc_taken_i = 1; wb_valid_i = 1;
    sample(); chk("exc_no_int", {31'd0, int_taken_o}, 32'd0); advance();
    idle_inputs();
    sample(); chk("exc_flush", {31'd0, flush_o}, 32'd1); advance();
    sample(); chk("exc_pc", redirect_pc_o, 32'h0000_0100);
    chk("exc_rv", {31'd0, redirect_valid_o}, 32'd1); advance();

    // Vectored external interrupt
    mtvec_i = 32'h0000_0201; mstatus_mie_i = 1; mie_i = 32'h0000_0800;
    xint_meip_i = 1; wb_valid_i = 1; wb_pc_i = 32'h0000_0040;
    sample();
    chk("vec_kill", {31'd0, kill_wb_o}, 32'd1);
    chk("vec_cause", int_mcause_o, 32'h8000_000B);
    chk("vec_mepc", int_mepc_o, 32'h0000_0040);
    advance();
    idle_inputs();
    cycle();
    sample(); chk("vec_pc", redirect_pc_o, 32'h0000_022C); advance();

    // Priority: exception beats all pending interrupts, then MEI, then MSI when MEIE=0
    mtvec_i = 32'h0000_0201; mstatus_mie_i = 1; mie_i = 32'h0000_0888;
    xint_meip_i = 1; xint_mtip_i = 1; xint_msip_i = 1; wb_valid_i = 1; wb_pc_i = 32'h0000_0080;
    exc_taken_i = 1;
    sample(); chk("prio_exc", {31'd0, int_taken_o}, 32'd0); advance();
    exc_taken_i = 0;
    cycle(); cycle();
    sample(); chk("prio_mei", int_mcause_o, 32'h8000_000B); advance();
    cycle(); cycle();
    mie_i = 32'h0000_0088;
    sample(); chk("prio_msi", int_mcause_o, 32'h8000_0003); advance();
    cycle();
    sample(); chk("prio_msi_pc", redirect_pc_o, 32'h0000_020C); advance();

    // MRET
    idle_inputs();
    mepc_i = 32'h0000_0042; mret_i = 1;
    sample(); chk("mret_on", {31'd0, mret_o}, 32'd1); advance();
    mret_i = 0;
    sample(); chk("mret_once", {31'd0, mret_o}, 32'd0); advance();
    sample(); chk("mret_pc", redirect_pc_o, 32'h0000_0040); advance();

    // Backpressure with an ignored exception while busy
    mtvec_i = 32'h0000_0300; exc_taken_i = 1; fetch_ready_i = 0;
    cycle();
    exc_taken_i = 0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin exc_taken_i = 1; mtvec_i = 32'h0000_0500; end
      else exc_taken_i = 0;
      sample();
      chk("bp_rv", {31'd0, redirect_valid_o}, 32'd1);
      chk("bp_pc", redirect_pc_o, 32'h0000_0300);
      advance();
    end
    exc_taken_i = 0; fetch_ready_i = 1;
    cycle();
    sample(); chk("bp_idle", {31'd0, busy_o}, 32'd0); advance();

    // Reset in the middle of REDIRECT
    mtvec_i = 32'h0000_0700; exc_taken_i = 1; fetch_ready_i = 0;
    cycle();
    exc_taken_i = 0;
    cycle();
    rst_i = 0;
    cycle();
    rst_i = 1;
    sample();
    chk("mr_rv", {31'd0, redirect_valid_o}, 32'd0);
    chk("mr_busy", {31'd0, busy_o}, 32'd0);
    chk("mr_pc", redirect_pc_o, RST_PC);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_i         = ($urandom_range(0, 49) != 0);
      xint_meip_i   = ($urandom_range(0, 2) == 0);
      xint_mtip_i   = ($urandom_range(0, 2) == 0);
      xint_msip_i   = ($urandom_range(0, 2) == 0);
      mstatus_mie_i = ($urandom_range(0, 3) != 0);
      mie_i         = $urandom();
      wb_valid_i    = ($urandom_range(0, 3) != 0);
      wb_pc_i       = $urandom();
      exc_taken_i   = ($urandom_range(0, 5) == 0);
      mret_i        = ($urandom_range(0, 4) == 0);
      mtvec_i       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE1 : $urandom();
      mepc_i        = $urandom();
      fetch_ready_i = ($urandom_range(0, 1) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_unit.md
# trap_unit

Trap sequencing unit for the machine-mode core. It samples the external, timer and software interrupt lines and decides, at the write-back boundary, whether to take an interrupt, a synchronous exception or an MRET. It drives the CSR-file trap-entry/return strobes and then runs a flush-and-redirect sequence toward fetch. It is the control counterpart of the write-back exception encoder, which only reports exceptions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value held on `redirect_pc_o` during and after reset.

Ports:
- `clk_i` input 1: sole clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous reset, active-low.
- `xint_meip_i`, `xint_mtip_i`, `xint_msip_i` input 1 each: external, timer and software interrupt pending levels. They are synchronous to `clk_i`.
- `mstatus_mie_i` input 1: global machine interrupt enable.
- `mie_i` input 32: per-source enables. Bit 11 is MEIE, bit 7 is MTIE, bit 3 is MSIE.
- `wb_valid_i` input 1: an instruction is present in WB this cycle.
- `wb_pc_i` input 32: PC of the WB instruction.
- `exc_taken_i` input 1: WB reports a synchronous exception this cycle.
- `mret_i` input 1: an MRET is retiring in WB this cycle.
- `mtvec_i`, `mepc_i` input 32: current CSR values.
- `fetch_ready_i` input 1: fetch accepts the redirect.
- `kill_wb_o` output 1: combinational; suppresses the WB register-file write in the interrupt-take cycle.
- `int_taken_o` output 1: one-cycle strobe to the CSR file to write `mcause`, `mepc` and `mstatus` for an interrupt.
- `int_mcause_o` output 32: interrupt cause, valid with `int_taken_o`.
- `int_mepc_o` output 32: the preempted PC, valid with `int_taken_o`.
- `mret_o` output 1: one-cycle strobe to the CSR file to restore MIE from MPIE.
- `flush_o` output 1: invalidates IF, ID, EX and MEM.
- `redirect_valid_o` output 1 and `redirect_pc_o` output 32: redirect request to fetch.
- `busy_o` output 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, FLUSH and REDIRECT.
- Pending interrupts are evaluated in IDLE:
  - `int_req` = `mstatus_mie_i` & `wb_valid_i` & !`exc_taken_i` & (any enabled pending source).
  - Priority among sources, highest first: MEI (code 11), MSI (code 3), MTI (code 7).
- Event priority in IDLE, highest first: `exc_taken_i`, then `int_req`, then `mret_i`. Exactly one event is accepted per cycle.
- Exception accepted:
  - target = {`mtvec_i`[31:2], 2'b00}.
  - No strobes from this block; the CSR file is updated by the WB exception path.
- Interrupt accepted:
  - `kill_wb_o` = 1 and `int_taken_o` = 1 in the same cycle.
  - `int_mcause_o` = {1'b1, 27'b0, code}.
  - `int_mepc_o` = `wb_pc_i`. The WB instruction is preempted and re-executes after return.
  - target when `mtvec_i`[1:0] == 2'b01 (vectored): {`mtvec_i`[31:2], 2'b00} + (code << 2), computed mod 2^32.
  - target for any other mode value: {`mtvec_i`[31:2], 2'b00}.
- MRET accepted:
  - `mret_o` = 1.
  - target = {`mepc_i`[31:2], 2'b00}.
- Any accepted event registers the target and moves the FSM IDLE -> FLUSH.
- FLUSH: `flush_o` = 1 for exactly one cycle, then -> REDIRECT.
- REDIRECT:
  - `redirect_valid_o` = 1 and `redirect_pc_o` = the registered target.
  - Both are held stable until `fetch_ready_i` = 1, then -> IDLE.
- In FLUSH and REDIRECT, all inputs other than `fetch_ready_i` are ignored. A second exception, interrupt or MRET gets no strobe and does not alter the target.
- Reset values, also applied on reset mid-sequence:
  - state = IDLE.
  - `flush_o`, `redirect_valid_o`, `int_taken_o`, `mret_o`, `kill_wb_o` and `busy_o` = 0.
  - `int_mcause_o` and `int_mepc_o` = 0.
  - `redirect_pc_o` = RESET_PC.

## Timing
- Event accepted in cycle T:
  - Strobes (`int_taken_o`, `mret_o`, `kill_wb_o`) are combinational in T.
  - `flush_o` = 1 in T+1.
  - `redirect_valid_o` is first high in T+2.
- Minimum latency from event to redirect handshake is 2 cycles; each extra cycle of `fetch_ready_i` = 0 adds 1.
- `fetch_ready_i` is don't-care outside REDIRECT.
- `busy_o` is high from T+1 through the handshake cycle, inclusive.
- Interrupt lines are sampled only in IDLE. A level that rises and falls while busy is not taken.

## Test plan
- Exception: `mtvec_i` = 32'h0000_0101, `exc_taken_i` = 1 at T -> `flush_o` at T+1, then `redirect_pc_o` = 32'h0000_0100 at T+2. No `int_taken_o`.
- Vectored interrupt:
  - Stimulus: `mtvec_i` = 32'h0000_0201, MIE = 1, MEIE = 1, `xint_meip_i` = 1, `wb_valid_i` = 1, `wb_pc_i` = 32'h0000_0040.
  - Response: `kill_wb_o` = 1 and `int_taken_o` = 1, `int_mcause_o` = 32'h8000_000B, `int_mepc_o` = 32'h0000_0040, `redirect_pc_o` = 32'h0000_022C.
- Priority:
  - All three sources pending and enabled together with `exc_taken_i` = 1 -> exception path taken, no interrupt strobe.
  - Next IDLE cycle with all three sources still pending -> code 11.
  - Same again with MEIE = 0 -> code 3.
- MRET: `mepc_i` = 32'h0000_0042, `mret_i` = 1 -> `mret_o` pulses once, `redirect_pc_o` = 32'h0000_0040.
- Backpressure and ignore:
  - Hold `fetch_ready_i` = 0 for 5 cycles -> `redirect_valid_o` and `redirect_pc_o` stay stable.
  - Pulse `exc_taken_i` while busy -> no effect.
  - Release `fetch_ready_i` -> IDLE on the next cycle.
- Reset mid-REDIRECT: drive `rst_i` = 0 for one cycle -> every output is at its reset value on the next cycle and the FSM is in IDLE.
